// File: rtl/riscv_mem_arbiter.sv
// Fetch / load-store arbiter in front of one single-ported, variable-latency memory.
// Data wins ties, a streak counter bounds fetch starvation, and a timeout turns a hung memory into bus_err.
module riscv_mem_arbiter #(
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        bus_err
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
    logic          err_q, err_d;
    logic          sel_data_q, sel_data_d;

    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          grant_data, grant_fetch;
    logic          latch_req, latch_rsp;
    logic          in_access, in_done;

    // Fetch only beats a pending data request once data has won MAX_STREAK times in a row.
    always_comb begin
        grant_data  = d_req && (!if_req || (streak_q != STREAK_MAX));
        grant_fetch = if_req && !grant_data;
    end

    assign tmo_inc = tmo_q + TW'(1);

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        sel_data_d = sel_data_q;
        latch_req  = 1'b0;
        latch_rsp  = 1'b0;
        rdata_d    = '0;
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (!if_req || grant_fetch) begin
                    streak_d = '0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + SW'(1);
                end
                if (grant_data || grant_fetch) begin
                    state_d    = ACCESS;
                    sel_data_d = grant_data;
                    err_d      = 1'b0;
                    latch_req  = 1'b1;
                end
            end
            ACCESS: begin
                tmo_d = tmo_inc;
                if (m_ack) begin
                    state_d   = DONE;
                    latch_rsp = 1'b1;
                    rdata_d   = we_q ? 32'h0 : m_rdata;
                end else if (tmo_inc == TMO_MAX) begin
                    state_d   = DONE;
                    err_d     = 1'b1;
                    latch_rsp = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                tmo_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetches are always full-word reads; loads also read the whole word regardless of d_be.
    always_comb begin
        we_d    = grant_data & d_we;
        addr_d  = grant_data ? d_addr : if_addr;
        wdata_d = grant_data ? d_wdata : 32'h0;
        be_d    = (grant_data && d_we) ? d_be : 4'hF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            sel_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            sel_data_q <= sel_data_d;
        end
    end

    // Request/response registers need no reset: every output they feed is gated by state_q.
    always_ff @(posedge clk) begin
        if (latch_req) begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
        if (latch_rsp) begin
            rdata_q <= rdata_d;
        end
    end

    assign in_access = (state_q == ACCESS);
    assign in_done   = (state_q == DONE);

    assign m_req   = in_access;
    assign m_we    = in_access & we_q;
    assign m_addr  = in_access ? addr_q  : 32'h0;
    assign m_wdata = in_access ? wdata_q : 32'h0;
    assign m_be    = in_access ? be_q    : 4'h0;

    assign if_done  = in_done & ~sel_data_q;
    assign d_done   = in_done & sel_data_q;
    assign bus_err  = in_done & err_q;
    assign if_rdata = if_done ? rdata_q : 32'h0;
    assign d_rdata  = d_done  ? rdata_q : 32'h0;

endmodule
